// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared opcodes, instruction field positions and sequencer
//               state encoding for the sequencer and the compute unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

    localparam logic [3:0] C_OP_NOP  = 4'h0;
    localparam logic [3:0] C_OP_ADD  = 4'h1;
    localparam logic [3:0] C_OP_SUB  = 4'h2;
    localparam logic [3:0] C_OP_AND  = 4'h3;
    localparam logic [3:0] C_OP_OR   = 4'h4;
    localparam logic [3:0] C_OP_SHL  = 4'h5;
    localparam logic [3:0] C_OP_SHR  = 4'h6;
    localparam logic [3:0] C_OP_XOR  = 4'h7;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    // Instruction layout: {opcode, tgt, src0, src1}
    localparam int C_OPC_MSB  = 15;
    localparam int C_OPC_LSB  = 12;
    localparam int C_TGT_MSB  = 11;
    localparam int C_TGT_LSB  = 8;
    localparam int C_SRC0_MSB = 7;
    localparam int C_SRC0_LSB = 4;
    localparam int C_SRC1_MSB = 3;
    localparam int C_SRC1_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic [3:0] instr_opcode(input logic [15:0] instr);
        return instr[C_OPC_MSB:C_OPC_LSB];
    endfunction

endpackage : instr_sequencer_pkg
`default_nettype wire

// File: rtl/instr_sequencer_prog_buffer.sv
`default_nettype none
// ============================================================================
// Module      : prog_buffer
// Description : Assembles byte pairs into 16-bit instructions and writes them
//               into the program memory; tracks length and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_buffer #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    input  logic          i_clear,
    input  logic          i_drop_partial,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data,
    output logic [AW:0]   o_prog_len,
    output logic          o_overflow
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = {{AW{1'b0}}, 1'b1};

    logic [15:0] mem [DEPTH];

    logic [7:0]  hi_q, hi_d;
    logic        phase_q, phase_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] prog_len_q, prog_len_d;
    logic        w_wr_en;
    logic        w_full;

    assign w_full = (prog_len_q == C_FULL);

    always_comb begin
        hi_d       = hi_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        prog_len_d = prog_len_q;
        w_wr_en    = 1'b0;
        if (i_clear) begin
            phase_d    = 1'b0;
            overflow_d = 1'b0;
            prog_len_d = '0;
        end else if (i_drop_partial) begin
            phase_d = 1'b0;
        end else if (i_byte_valid) begin
            if (w_full) begin
                overflow_d = 1'b1;
            end else if (!phase_q) begin
                hi_d    = i_byte;
                phase_d = 1'b1;
            end else begin
                w_wr_en    = 1'b1;
                prog_len_d = prog_len_q + C_ONE;
                phase_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            phase_q    <= 1'b0;
            overflow_q <= 1'b0;
            prog_len_q <= '0;
        end else begin
            hi_q       <= hi_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
            prog_len_q <= prog_len_d;
        end
    end

    // Storage is deliberately not reset; a zero length hides stale entries.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[prog_len_q[AW-1:0]] <= {hi_q, i_byte};
        end
    end

    assign o_rd_data  = mem[i_rd_addr];
    assign o_prog_len = prog_len_q;
    assign o_overflow = overflow_q;

endmodule : prog_buffer
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Loads a byte-serial program and issues it downstream over a
//               valid/ready handshake, with halt, loop and abort control.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   abort,
    input  logic                   loop_en,
    output logic [15:0]            instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] prog_len
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          w_idle;
    logic          w_run;
    logic          w_clear;
    logic          w_start_go;
    logic          w_load;
    logic          w_halt;
    logic          w_xfer;
    logic          w_last;
    logic [15:0]   w_rd_data;

    assign w_idle  = (state_q == ST_IDLE);
    assign w_run   = (state_q == ST_RUN);
    // clear outranks start, start outranks a same-cycle load byte
    assign w_clear    = w_idle & clear;
    assign w_start_go = w_idle & ~clear & start & (prog_len != '0);
    assign w_load     = w_idle & ~clear & ~start & byte_valid;

    prog_buffer #(
        .DEPTH (DEPTH)
    ) u_prog_buffer (
        .clk            (clk),
        .rst            (rst),
        .i_byte         (byte_in),
        .i_byte_valid   (w_load),
        .i_clear        (w_clear),
        .i_drop_partial (w_start_go),
        .i_rd_addr      (pc_q),
        .o_rd_data      (w_rd_data),
        .o_prog_len     (prog_len),
        .o_overflow     (overflow)
    );

    assign w_halt      = (instr_opcode(w_rd_data) == C_OP_HALT);
    assign instr_valid = w_run & ~w_halt;
    assign instr_out   = w_run ? w_rd_data : 16'h0000;
    assign w_xfer      = instr_valid & instr_ready;
    assign w_last      = ({1'b0, pc_q} == (prog_len - C_ONE));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start_go) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end else if (w_halt) begin
                    state_d = ST_DONE;
                    pc_d    = '0;
                end else if (w_xfer) begin
                    if (!w_last) begin
                        pc_d = pc_q + 1'b1;
                    end else begin
                        pc_d = '0;
                        if (!loop_en) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule : instr_sequencer
`default_nettype wire
